terminal_sequence_arbiter: RTL and testbench

Shares the single host-bound byte stream between the keyboard encoder and the mouse encoder. Each encoder emits one-cycle sequence pulses (up to 4 bytes packed LSB-first with a byte count). The block buffers one pending sequence per source, filters mouse events according to the mouse reporting mode, and serializes whole sequences atomically onto a ready/valid byte interface feeding the serial transmit FIFO. Sources are arbitrated round-robin.

---
 rtl/terminal_sequence_arbiter_pkg.sv | 41 ++++
 rtl/terminal_sequence_arbiter_if.sv | 15 +
 rtl/terminal_sequence_arbiter_sequence_holding_reg.sv | 63 ++++++
 rtl/terminal_sequence_arbiter.sv | 154 +++++++++++++++
 tb/tb_terminal_sequence_arbiter.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/terminal_sequence_arbiter_pkg.sv
// terminal_sequence_arbiter_pkg
// Shared constants and types for the terminal sequence arbiter: mouse
// reporting modes, FSM state / source encodings, the holding-register entry
// and the byte-count clamp helper.
package terminal_sequence_arbiter_pkg;

  localparam int SEQ_BYTES = 4;
  localparam int BYTE_W    = 8;
  localparam int SEQ_W     = SEQ_BYTES * BYTE_W;
  localparam int CNT_W     = 3;

  // Mouse reporting modes; mode 3 behaves like MOUSE_ALL.
  localparam logic [1:0] MOUSE_OFF    = 2'd0;
  localparam logic [1:0] MOUSE_CLICKS = 2'd1;
  localparam logic [1:0] MOUSE_ALL    = 2'd2;

  // Button field inside the mouse modifier byte.
  localparam int BTN_LSB = 8;
  localparam int BTN_W   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_KBD   = 1'b0,
    SRC_MOUSE = 1'b1
  } src_e;

  typedef struct packed {
    logic [SEQ_W-1:0] seq;
    logic [CNT_W-1:0] count;
  } seq_entry_t;

  // Counts above the sequence width are treated as a full-width sequence.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] c);
    return (c > CNT_W'(SEQ_BYTES)) ? CNT_W'(SEQ_BYTES) : c;
  endfunction

endpackage

// File: rtl/terminal_sequence_arbiter_if.sv
// terminal_sequence_arbiter_if
// Ready/valid byte stream toward the serial transmit FIFO.
//   byte_out   : current byte (driven by master)
//   byte_valid : byte_out is valid (driven by master)
//   byte_ready : downstream accepts byte_out this cycle (driven by slave)
interface terminal_sequence_arbiter_if
  import terminal_sequence_arbiter_pkg::*;
;
  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/terminal_sequence_arbiter_sequence_holding_reg.sv
// sequence_holding_reg
// One pending sequence per source: {sequence, clamped count} plus a full bit.
// With OVERWRITE=1 a new load always replaces the held entry (coalescing);
// with OVERWRITE=0 a load only lands when the register is empty or is being
// granted in the same cycle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load_i     : a new sequence is offered this cycle
//   seq_i      : offered sequence, byte 0 in [7:0]
//   count_i    : offered byte count (clamped on load)
//   grant_i    : the held entry is taken by the arbiter this cycle
//   entry_o    : held entry
//   full_o     : entry is valid
//   accept_o   : the offered sequence was stored
module sequence_holding_reg
  import terminal_sequence_arbiter_pkg::*;
#(
  parameter bit OVERWRITE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [SEQ_W-1:0] seq_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             grant_i,
  output seq_entry_t       entry_o,
  output logic             full_o,
  output logic             accept_o
);

  seq_entry_t entry_q, entry_d;
  logic       full_q, full_d;
  logic       accept;

  // A grant reads entry_q this cycle, so a same-cycle load can safely land
  // behind it and keep the register full.
  always_comb begin
    accept  = load_i && (OVERWRITE || !full_q || grant_i);
    entry_d = entry_q;
    full_d  = full_q;
    if (grant_i) full_d = 1'b0;
    if (accept) begin
      entry_d.seq   = seq_i;
      entry_d.count = clamp_count(count_i);
      full_d        = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      entry_q <= '0;
      full_q  <= 1'b0;
    end else begin
      entry_q <= entry_d;
      full_q  <= full_d;
    end
  end

  assign entry_o  = entry_q;
  assign full_o   = full_q;
  assign accept_o = accept;

endmodule

// File: rtl/terminal_sequence_arbiter.sv
// terminal_sequence_arbiter
// Merges keyboard and mouse escape sequences into one host-bound byte
// stream. Each source has a one-deep holding register; mouse events are
// filtered by reporting mode and coalesced. Whole sequences are sent
// atomically, sources alternate round-robin on ties.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   mouse_control_i  : 0 off, 1 button changes only, 2/3 all events
//   kbd_sequence_i   : keyboard sequence, byte 0 in [7:0]
//   kbd_count_i      : keyboard byte count, 0 = no event, >4 clamps to 4
//   mouse_sequence_i : mouse sequence, buttons in [10:8]
//   mouse_count_i    : mouse byte count, same encoding
//   host_if          : ready/valid byte stream (master side)
//   kbd_overflow_o   : sticky, a keyboard sequence was dropped
//   busy_o           : sending, or a holding register is full
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no byte offered; grant a full holding register if any
// ST_SEND | byte_out valid; shift out remaining bytes on each byte_ready
module terminal_sequence_arbiter
  import terminal_sequence_arbiter_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [1:0]                 mouse_control_i,
  input  logic [SEQ_W-1:0]           kbd_sequence_i,
  input  logic [CNT_W-1:0]           kbd_count_i,
  input  logic [SEQ_W-1:0]           mouse_sequence_i,
  input  logic [CNT_W-1:0]           mouse_count_i,
  terminal_sequence_arbiter_if.master host_if,
  output logic                       kbd_overflow_o,
  output logic                       busy_o
);

  localparam int SHIFT_W = SEQ_W - BYTE_W;

  arb_state_e        state_q;
  src_e              last_grant_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BYTE_W-1:0] byte_out_q;
  logic              byte_valid_q;
  logic              kbd_overflow_q;
  logic [BTN_W-1:0]  last_buttons_q;

  logic       kbd_load, mouse_load, mouse_pass;
  logic       kbd_full, mouse_full;
  logic       kbd_accept, mouse_accept;
  logic       grant_kbd, grant_mouse;
  seq_entry_t kbd_entry, mouse_entry, grant_entry;

  always_comb begin
    mouse_pass = 1'b0;
    case (mouse_control_i)
      MOUSE_OFF:    mouse_pass = 1'b0;
      MOUSE_CLICKS: mouse_pass = (mouse_sequence_i[BTN_LSB +: BTN_W] != last_buttons_q);
      default:      mouse_pass = 1'b1;
    endcase
  end

  assign kbd_load   = (kbd_count_i != '0);
  assign mouse_load = (mouse_count_i != '0) && mouse_pass;

  sequence_holding_reg #(.OVERWRITE(1'b0)) u_kbd_hold (
    .clk      (clk),
    .reset    (reset),
    .load_i   (kbd_load),
    .seq_i    (kbd_sequence_i),
    .count_i  (kbd_count_i),
    .grant_i  (grant_kbd),
    .entry_o  (kbd_entry),
    .full_o   (kbd_full),
    .accept_o (kbd_accept)
  );

  sequence_holding_reg #(.OVERWRITE(1'b1)) u_mouse_hold (
    .clk      (clk),
    .reset    (reset),
    .load_i   (mouse_load),
    .seq_i    (mouse_sequence_i),
    .count_i  (mouse_count_i),
    .grant_i  (grant_mouse),
    .entry_o  (mouse_entry),
    .full_o   (mouse_full),
    .accept_o (mouse_accept)
  );

  // Keyboard wins a tie unless it was the last source served.
  always_comb begin
    grant_kbd   = 1'b0;
    grant_mouse = 1'b0;
    if (state_q == ST_IDLE) begin
      if (kbd_full && (!mouse_full || last_grant_q == SRC_MOUSE)) grant_kbd = 1'b1;
      else if (mouse_full) grant_mouse = 1'b1;
    end
    grant_entry = grant_kbd ? kbd_entry : mouse_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= SRC_MOUSE;
      shift_q      <= '0;
      cnt_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_kbd || grant_mouse) begin
            last_grant_q <= grant_kbd ? SRC_KBD : SRC_MOUSE;
            byte_out_q   <= grant_entry.seq[BYTE_W-1:0];
            shift_q      <= grant_entry.seq[SEQ_W-1:BYTE_W];
            cnt_q        <= grant_entry.count;
            byte_valid_q <= 1'b1;
            state_q      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (host_if.byte_ready) begin
            if (cnt_q == CNT_W'(1)) begin
              byte_valid_q <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              byte_out_q <= shift_q[BYTE_W-1:0];
              shift_q    <= {{BYTE_W{1'b0}}, shift_q[SHIFT_W-1:BYTE_W]};
              cnt_q      <= cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Mouse-filter history follows every accepted mouse event; the mouse
  // register always accepts a filtered-in event.
  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_overflow_q <= 1'b0;
      last_buttons_q <= '0;
    end else begin
      if (kbd_load && !kbd_accept) kbd_overflow_q <= 1'b1;
      if (mouse_accept) last_buttons_q <= mouse_sequence_i[BTN_LSB +: BTN_W];
    end
  end

  assign host_if.byte_out   = byte_out_q;
  assign host_if.byte_valid = byte_valid_q;
  assign kbd_overflow_o     = kbd_overflow_q;
  assign busy_o             = (state_q == ST_SEND) || kbd_full || mouse_full;

endmodule

// File: tb/tb_terminal_sequence_arbiter.sv
module tb_terminal_sequence_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mouse_control;
  logic [31:0] kbd_seq, mouse_seq;
  logic [2:0]  kbd_cnt, mouse_cnt;
  logic        kbd_overflow, busy;

  terminal_sequence_arbiter_if host_if();

  terminal_sequence_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .mouse_control_i  (mouse_control),
    .kbd_sequence_i   (kbd_seq),
    .kbd_count_i      (kbd_cnt),
    .mouse_sequence_i (mouse_seq),
    .mouse_count_i    (mouse_cnt),
    .host_if          (host_if),
    .kbd_overflow_o   (kbd_overflow),
    .busy_o           (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] rx_q[$];

  logic [31:0] t5_seq [4] = '{32'h00A0001B, 32'h00A1011B, 32'h00A2011B, 32'h00A3001B};

  // Bytes actually handed downstream (valid && ready at the next edge).
  always @(negedge clk)
    if (!reset && host_if.byte_valid && host_if.byte_ready)
      rx_q.push_back(host_if.byte_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    kbd_cnt = '0;
    mouse_cnt = '0;
    host_if.byte_ready = 1'b1;
    tick(2);
    reset = 1'b0;
    rx_q.delete();
  endtask

  // exp holds the expected stream packed LSB-first, n bytes long.
  task automatic check_stream(input string tag, input logic [63:0] exp, input int n);
    logic [7:0] got;
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      chk($sformatf("%s[%0d]", tag, i), 32'(got), 32'(exp[8*i +: 8]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_valid, prev_ready;
    logic [7:0] prev_byte;

    reset = 1'b1;
    mouse_control = 2'd2;
    kbd_seq = '0;
    mouse_seq = '0;
    kbd_cnt = '0;
    mouse_cnt = '0;
    host_if.byte_ready = 1'b1;
    tick(3);
    chk("rst_valid", 32'(host_if.byte_valid), 32'd0);
    chk("rst_byte", 32'(host_if.byte_out), 32'd0);
    chk("rst_ovf", 32'(kbd_overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // single keyboard sequence, exact cycle timing
    kbd_seq = 32'h00415B1B; kbd_cnt = 3'd3;
    tick; kbd_cnt = '0;
    chk("t1_busy_n1", 32'(busy), 32'd1);
    chk("t1_valid_n1", 32'(host_if.byte_valid), 32'd0);
    tick;
    chk("t1_valid_n2", 32'(host_if.byte_valid), 32'd1);
    chk("t1_byte_n2", 32'(host_if.byte_out), 32'h1B);
    tick;
    chk("t1_byte_n3", 32'(host_if.byte_out), 32'h5B);
    tick;
    chk("t1_byte_n4", 32'(host_if.byte_out), 32'h41);
    chk("t1_valid_n4", 32'(host_if.byte_valid), 32'd1);
    tick;
    chk("t1_valid_n5", 32'(host_if.byte_valid), 32'd0);
    chk("t1_busy_n5", 32'(busy), 32'd0);

    // simultaneous keyboard + mouse after reset, keyboard first
    do_reset();
    mouse_control = 2'd2;
    kbd_seq = 32'h00635B1B; kbd_cnt = 3'd3;
    mouse_seq = 32'h0503201B; mouse_cnt = 3'd4;
    tick; kbd_cnt = '0; mouse_cnt = '0;
    tick(12);
    check_stream("t2_tie", 64'h0005_0320_1B63_5B1B, 7);

    // alternation: tie after mouse grant -> kbd; kbd alone; tie -> mouse
    rx_q.delete();
    kbd_seq = 32'h61; kbd_cnt = 3'd1;
    mouse_seq = 32'h4D; mouse_cnt = 3'd1;
    tick; kbd_cnt = '0; mouse_cnt = '0;
    tick(6);
    kbd_seq = 32'h62; kbd_cnt = 3'd1;
    tick; kbd_cnt = '0;
    tick(4);
    kbd_seq = 32'h63; kbd_cnt = 3'd1;
    mouse_seq = 32'h4E; mouse_cnt = 3'd1;
    tick; kbd_cnt = '0; mouse_cnt = '0;
    tick(6);
    check_stream("t2_rr", 64'h63_4E62_4D61, 5);

    // keyboard overflow under backpressure
    do_reset();
    host_if.byte_ready = 1'b0;
    kbd_seq = 32'h41; kbd_cnt = 3'd1;
    tick; kbd_seq = 32'h42;
    tick; kbd_seq = 32'h43;
    tick; kbd_cnt = '0;
    chk("t3_ovf", 32'(kbd_overflow), 32'd1);
    chk("t3_valid", 32'(host_if.byte_valid), 32'd1);
    chk("t3_byte", 32'(host_if.byte_out), 32'h41);
    tick(2);
    chk("t3_byte_hold", 32'(host_if.byte_out), 32'h41);
    host_if.byte_ready = 1'b1;
    tick(6);
    check_stream("t3_stream", 64'h4241, 2);
    chk("t3_ovf_sticky", 32'(kbd_overflow), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // mouse coalescing while keyboard sends; counts 7/5 clamp to 4
    do_reset();
    mouse_control = 2'd2;
    kbd_seq = 32'h44434241; kbd_cnt = 3'd7;
    tick; kbd_cnt = '0;
    mouse_seq = 32'h1081201B; mouse_cnt = 3'd5;
    tick;
    mouse_seq = 32'h1085201B; mouse_cnt = 3'd4;
    tick; mouse_cnt = '0;
    tick(12);
    check_stream("t4_coal", 64'h1085_201B_4443_4241, 8);
    chk("t4_ovf", 32'(kbd_overflow), 32'd0);

    // mode 1: only button changes pass
    do_reset();
    mouse_control = 2'd1;
    for (int i = 0; i < 4; i++) begin
      mouse_seq = t5_seq[i]; mouse_cnt = 3'd3;
      tick; mouse_cnt = '0;
      tick(6);
    end
    check_stream("t5_clicks", 64'h0000_A300_1BA1_011B, 6);

    // mode 0: nothing passes
    rx_q.delete();
    mouse_control = 2'd0;
    mouse_seq = 32'h00A4071B; mouse_cnt = 3'd3;
    tick; mouse_cnt = '0;
    tick(6);
    chk("t5_off_len", 32'(rx_q.size()), 32'd0);
    chk("t5_off_busy", 32'(busy), 32'd0);

    // backpressure: byte held stable until accepted
    do_reset();
    mouse_control = 2'd2;
    host_if.byte_ready = 1'b0;
    kbd_seq = 32'h00635B1B; kbd_cnt = 3'd3;
    tick; kbd_cnt = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_byte = '0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (prev_valid && !prev_ready)
        chk($sformatf("t6_hold%0d", i), 32'(host_if.byte_out), 32'(prev_byte));
      prev_valid = host_if.byte_valid;
      prev_byte = host_if.byte_out;
      host_if.byte_ready = ~host_if.byte_ready;
      prev_ready = host_if.byte_ready;
    end
    check_stream("t6_bp", 64'h635B1B, 3);

    // reset mid-sequence abandons everything
    do_reset();
    mouse_control = 2'd2;
    kbd_seq = 32'h44434241; kbd_cnt = 3'd4;
    mouse_seq = 32'h4D; mouse_cnt = 3'd1;
    tick; kbd_cnt = '0; mouse_cnt = '0;
    tick(2);
    chk("t6_mid_valid", 32'(host_if.byte_valid), 32'd1);
    chk("t6_mid_byte", 32'(host_if.byte_out), 32'h42);
    reset = 1'b1;
    tick;
    chk("t6_rst_valid", 32'(host_if.byte_valid), 32'd0);
    chk("t6_rst_byte", 32'(host_if.byte_out), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    rx_q.delete();
    tick(10);
    chk("t6_after_len", 32'(rx_q.size()), 32'd0);
    chk("t6_after_busy", 32'(busy), 32'd0);
    chk("t6_after_valid", 32'(host_if.byte_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
